// File: rtl/filter_dot_product_pkg.sv
// rtl/filter_dot_product_pkg.sv - shared element type, default widths and Q8.8 saturation bounds
package filter_dot_product_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;

  typedef logic signed [DEF_DATA_W-1:0] elem_t;

  localparam elem_t SAT_MAX = elem_t'(2**(DEF_DATA_W-1) - 1);
  localparam elem_t SAT_MIN = elem_t'(-(2**(DEF_DATA_W-1)));

endpackage

// File: rtl/filter_dot_product_mac_lane.sv
// rtl/filter_dot_product_mac_lane.sv - one filter lane: product, accumulate, finalize, shift/saturate
// Optional ReLU clamp on the saturated result when FILTER_DOT_PRODUCT_RELU_EN is defined.
module filter_dot_product_mac_lane
  import filter_dot_product_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = 40
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     beat_i,
  input  logic                     s1_valid_i,
  input  logic                     s1_last_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic        [DATA_W-1:0] sat_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] a_ext, b_ext;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  fin_q, fin_d;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  shifted;

  always_comb begin
    a_ext   = PROD_W'(a_i);
    b_ext   = PROD_W'(b_i);
    prod_d  = beat_i ? a_ext * b_ext : prod_q;
    acc_sum = acc_q + ACC_W'(prod_q);
    acc_d   = acc_q;
    fin_d   = fin_q;
    // The last beat hands its sum to finalize and restarts the accumulator,
    // so a following vector can stream in without a bubble.
    if (s1_valid_i) begin
      if (s1_last_i) begin
        fin_d = acc_sum;
        acc_d = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_comb begin
    shifted = fin_q >>> FRAC_W;
    if (shifted > ACC_W'(SAT_MAX)) begin
      sat_o = DATA_W'(SAT_MAX);
    end else if (shifted < ACC_W'(SAT_MIN)) begin
      sat_o = DATA_W'(SAT_MIN);
    end else begin
      sat_o = shifted[DATA_W-1:0];
    end
`ifdef FILTER_DOT_PRODUCT_RELU_EN
    if (sat_o[DATA_W-1]) begin
      sat_o = '0;
    end
`endif
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      prod_q <= '0;
      acc_q  <= '0;
      fin_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      fin_q  <= fin_d;
    end
  end

endmodule

// File: rtl/filter_dot_product.sv
// rtl/filter_dot_product.sv - four-lane Q8.8 dot product with result handshake and sticky error flags
// Build option: FILTER_DOT_PRODUCT_RELU_EN clamps negative results to zero.
module filter_dot_product
  import filter_dot_product_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FRAC_W       = DEF_FRAC_W,
  parameter int ACC_W        = 40,
  parameter int NUM_ELEMENTS = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              en,
  input  logic              b_element_ready,
  input  logic [DATA_W-1:0] b0_element,
  input  logic [DATA_W-1:0] b1_element,
  input  logic [DATA_W-1:0] b2_element,
  input  logic [DATA_W-1:0] b3_element,
  input  logic [DATA_W-1:0] a_element,
  input  logic              last_element,
  input  logic              result_ready,
  output logic              result_valid,
  output logic [DATA_W-1:0] result0,
  output logic [DATA_W-1:0] result1,
  output logic [DATA_W-1:0] result2,
  output logic [DATA_W-1:0] result3,
  output logic              length_error,
  output logic              overrun
);

  localparam int              CNT_W    = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ELEMENTS - 1);

  logic              beat;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic              fin_valid_q, fin_valid_d;
  logic [CNT_W-1:0]  beat_count_q, beat_count_d;
  logic              length_error_q, length_error_d;
  logic              overrun_q, overrun_d;
  logic              result_valid_q, result_valid_d;
  logic [DATA_W-1:0] result_q [4];
  logic [DATA_W-1:0] result_d [4];
  logic [DATA_W-1:0] sat      [4];
  logic [DATA_W-1:0] b_lane   [4];

  assign b_lane[0] = b0_element;
  assign b_lane[1] = b1_element;
  assign b_lane[2] = b2_element;
  assign b_lane[3] = b3_element;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    filter_dot_product_mac_lane #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clock     (clock),
      .clear_n   (clear_n),
      .beat_i    (beat),
      .s1_valid_i(s1_valid_q),
      .s1_last_i (s1_last_q),
      .a_i       (a_element),
      .b_i       (b_lane[i]),
      .sat_o     (sat[i])
    );
  end

  always_comb begin
    beat           = en && b_element_ready;
    s1_valid_d     = beat;
    s1_last_d      = beat && last_element;
    fin_valid_d    = s1_valid_q && s1_last_q;
    beat_count_d   = beat_count_q;
    length_error_d = length_error_q;
    // A vector running past NUM_ELEMENTS is flagged and the count wraps,
    // but accumulation carries on until the real last beat.
    if (beat) begin
      if (last_element) begin
        if (beat_count_q != CNT_LAST) begin
          length_error_d = 1'b1;
        end
        beat_count_d = '0;
      end else if (beat_count_q == CNT_LAST) begin
        length_error_d = 1'b1;
        beat_count_d   = '0;
      end else begin
        beat_count_d = beat_count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q;
    result_d       = result_q;
    if (result_valid_q && result_ready) begin
      result_valid_d = 1'b0;
    end
    // A completion always lands; it only counts as overrun if the held result was not taken.
    if (fin_valid_q) begin
      result_valid_d = 1'b1;
      result_d       = sat;
      if (result_valid_q && !result_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      s1_valid_q     <= 1'b0;
      s1_last_q      <= 1'b0;
      fin_valid_q    <= 1'b0;
      beat_count_q   <= '0;
      length_error_q <= 1'b0;
      overrun_q      <= 1'b0;
      result_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        result_q[i] <= '0;
      end
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_last_q      <= s1_last_d;
      fin_valid_q    <= fin_valid_d;
      beat_count_q   <= beat_count_d;
      length_error_q <= length_error_d;
      overrun_q      <= overrun_d;
      result_valid_q <= result_valid_d;
      for (int i = 0; i < 4; i++) begin
        result_q[i] <= result_d[i];
      end
    end
  end

  assign result_valid = result_valid_q;
  assign result0      = result_q[0];
  assign result1      = result_q[1];
  assign result2      = result_q[2];
  assign result3      = result_q[3];
  assign length_error = length_error_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_filter_dot_product.sv
// tb/tb_filter_dot_product.sv - randomized self-checking bench for filter_dot_product
module tb_filter_dot_product;

  localparam int DATA_W = 16;
  localparam int N      = 16;

`ifdef FILTER_DOT_PRODUCT_RELU_EN
  localparam logic [15:0] EXP_BASIC_R2 = 16'h0000;
  localparam logic [15:0] EXP_SAT_R1   = 16'h0000;
  localparam logic [15:0] EXP_SAT_R3   = 16'h0000;
`else
  localparam logic [15:0] EXP_BASIC_R2 = 16'hF000;
  localparam logic [15:0] EXP_SAT_R1   = 16'h8000;
  localparam logic [15:0] EXP_SAT_R3   = 16'hF800;
`endif

  logic              clock = 1'b0;
  logic              clear_n;
  logic              en;
  logic              b_element_ready;
  logic [DATA_W-1:0] b0_element, b1_element, b2_element, b3_element;
  logic [DATA_W-1:0] a_element;
  logic              last_element;
  logic              result_ready;
  logic              result_valid;
  logic [DATA_W-1:0] result0, result1, result2, result3;
  logic              length_error;
  logic              overrun;

  int          vectors     = 0;
  int          miscompares = 0;
  bit          mon_en      = 1'b0;
  bit          exp_len_err = 1'b0;
  bit          exp_overrun = 1'b0;
  int          va[$];
  int          vb[4][$];
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [63:0] held_exp;

  always #5 clock = ~clock;

  filter_dot_product dut (
    .clock          (clock),
    .clear_n        (clear_n),
    .en             (en),
    .b_element_ready(b_element_ready),
    .b0_element     (b0_element),
    .b1_element     (b1_element),
    .b2_element     (b2_element),
    .b3_element     (b3_element),
    .a_element      (a_element),
    .last_element   (last_element),
    .result_ready   (result_ready),
    .result_valid   (result_valid),
    .result0        (result0),
    .result1        (result1),
    .result2        (result2),
    .result3        (result3),
    .length_error   (length_error),
    .overrun        (overrun)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Dot product of the current vector for one lane, from plain integer arithmetic.
  function automatic logic [15:0] ref_lane(input int l);
    longint sum = 0;
    longint q;
    for (int i = 0; i < va.size(); i++) begin
      sum += longint'(va[i]) * longint'(vb[l][i]);
    end
    q = sum >>> 8;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`ifdef FILTER_DOT_PRODUCT_RELU_EN
    if (q < 0) q = 0;
`endif
    return 16'(q);
  endfunction

  function automatic logic [63:0] ref_vec();
    return {ref_lane(3), ref_lane(2), ref_lane(1), ref_lane(0)};
  endfunction

  function automatic int rand_elem();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 1023)) - 512;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic fill_const(input int n, input int a, input int b0, input int b1,
                            input int b2, input int b3);
    va.delete();
    for (int l = 0; l < 4; l++) vb[l].delete();
    for (int i = 0; i < n; i++) begin
      va.push_back(a);
      vb[0].push_back(b0);
      vb[1].push_back(b1);
      vb[2].push_back(b2);
      vb[3].push_back(b3);
    end
  endtask

  task automatic fill_rand(input int n);
    va.delete();
    for (int l = 0; l < 4; l++) vb[l].delete();
    for (int i = 0; i < n; i++) begin
      va.push_back(rand_elem());
      for (int l = 0; l < 4; l++) vb[l].push_back(rand_elem());
    end
  endtask

  task automatic scramble_data();
    a_element  = 16'($urandom);
    b0_element = 16'($urandom);
    b1_element = 16'($urandom);
    b2_element = 16'($urandom);
    b3_element = 16'($urandom);
  endtask

  task automatic set_idle();
    en              = 1'b0;
    b_element_ready = 1'b0;
    last_element    = 1'b0;
    scramble_data();
  endtask

  task automatic set_stall();
    case ($urandom_range(0, 2))
      0:       begin en = 1'b0; b_element_ready = 1'b1; end
      1:       begin en = 1'b1; b_element_ready = 1'b0; end
      default: begin en = 1'b0; b_element_ready = 1'b0; end
    endcase
    last_element = 1'($urandom_range(0, 1));
    scramble_data();
  endtask

  task automatic drive_range(input int from, input int to, input int gap_pct);
    for (int i = from; i < to; i++) begin
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin
          set_stall();
          step();
        end
      end
      en              = 1'b1;
      b_element_ready = 1'b1;
      last_element    = (i == va.size() - 1);
      a_element       = 16'(va[i]);
      b0_element      = 16'(vb[0][i]);
      b1_element      = 16'(vb[1][i]);
      b2_element      = 16'(vb[2][i]);
      b3_element      = 16'(vb[3][i]);
      if (last_element) begin
        exp_q.push_back(ref_vec());
        exp_len_err |= (va.size() != N);
      end
      step();
    end
    set_idle();
  endtask

  task automatic drive_vec(input int gap_pct);
    drive_range(0, va.size(), gap_pct);
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    clear_n = 1'b0;
    set_idle();
    step();
    step();
    check_eq("rst_flags", {result_valid, length_error, overrun}, 64'd0);
    check_eq("rst_results", {result3, result2, result1, result0}, 64'd0);
    clear_n     = 1'b1;
    exp_len_err = 1'b0;
    exp_overrun = 1'b0;
    exp_q.delete();
    mon_en      = 1'b1;
    step();
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_len_err"}, length_error, exp_len_err);
    check_eq({tag, "_overrun"}, overrun, exp_overrun);
  endtask

  always @(negedge clock) begin
    if (mon_en && clear_n && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", result_valid, 1'b0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("res0", result0, mon_exp[15:0]);
        check_eq("res1", result1, mon_exp[31:16]);
        check_eq("res2", result2, mon_exp[47:32]);
        check_eq("res3", result3, mon_exp[63:48]);
      end
    end
  end

  initial begin
    result_ready = 1'b1;
    do_reset();

    fill_const(16, 256, 256, 512, -256, 128);
    drive_vec(0);
    check_eq("lat_c1", result_valid, 1'b0);
    step();
    check_eq("lat_c2", result_valid, 1'b0);
    step();
    check_eq("lat_c3", result_valid, 1'b1);
    check_eq("basic", {result3, result2, result1, result0}, {16'h0800, EXP_BASIC_R2, 16'h2000, 16'h1000});
    step();
    check_eq("basic_accept", result_valid, 1'b0);

    fill_const(16, 32767, 32767, -32768, 0, -1);
    drive_vec(0);
    step();
    step();
    check_eq("sat_r0", result0, 16'h7FFF);
    check_eq("sat_r1", result1, EXP_SAT_R1);
    check_eq("sat_r2", result2, 16'h0000);
    check_eq("floor_r3", result3, EXP_SAT_R3);
    repeat (2) step();

    fill_const(16, 256, 256, 256, 256, 256);
    drive_vec(0);
    fill_const(16, 256, 512, 512, 512, 512);
    drive_vec(0);
    repeat (4) step();
    check_eq("b2b_drained", exp_q.size(), 0);

    for (int v = 0; v < 24; v++) begin
      fill_rand(16);
      drive_vec(30);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) step();
    end
    repeat (5) step();
    check_eq("rand_drained", exp_q.size(), 0);
    check_flags("rand");

    mon_en       = 1'b0;
    result_ready = 1'b0;
    fill_const(16, 256, 256, 256, 256, 256);
    drive_vec(0);
    repeat (4) step();
    check_eq("hold_valid", result_valid, 1'b1);
    check_eq("hold_a", {result3, result2, result1, result0}, 64'h1000_1000_1000_1000);
    fill_rand(16);
    drive_vec(0);
    held_exp = exp_q[1];
    step();
    result_ready = 1'b1;
    step();
    check_eq("same_cycle_valid", result_valid, 1'b1);
    check_eq("same_cycle_b", {result3, result2, result1, result0}, held_exp);
    check_flags("same_cycle");
    step();
    check_eq("same_cycle_accept", result_valid, 1'b0);
    exp_q.delete();

    result_ready = 1'b0;
    fill_rand(16);
    drive_vec(0);
    repeat (4) step();
    check_eq("bp_a", {result3, result2, result1, result0}, exp_q[0]);
    check_eq("bp_a_overrun", overrun, 1'b0);
    fill_rand(16);
    drive_vec(0);
    step();
    check_eq("bp_pre_overrun", overrun, 1'b0);
    step();
    exp_overrun = 1'b1;
    check_eq("bp_b", {result3, result2, result1, result0}, exp_q[1]);
    check_flags("bp");
    repeat (3) step();
    check_eq("bp_held_valid", result_valid, 1'b1);
    check_eq("bp_held_b", {result3, result2, result1, result0}, exp_q[1]);
    result_ready = 1'b1;
    step();
    check_eq("bp_release", result_valid, 1'b0);
    check_eq("bp_sticky", overrun, 1'b1);
    exp_q.delete();

    do_reset();
    fill_rand(10);
    drive_vec(20);
    repeat (4) step();
    check_eq("short_drained", exp_q.size(), 0);
    check_flags("short");

    do_reset();
    fill_rand(17);
    drive_range(0, 16, 0);
    check_eq("wrap_err", length_error, 1'b1);
    drive_range(16, 17, 0);
    repeat (4) step();
    check_eq("long_drained", exp_q.size(), 0);
    check_flags("long");

    fill_rand(16);
    drive_range(0, 7, 0);
    clear_n = 1'b0;
    #1;
    check_eq("midrst_flags", {result_valid, length_error, overrun}, 64'd0);
    do_reset();
    fill_rand(16);
    drive_vec(0);
    repeat (4) step();
    check_eq("post_rst_drained", exp_q.size(), 0);
    check_flags("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/filter_dot_product.md
Name: filter_dot_product

Overview:
- Downstream consumer of the filter memory manager.
- Takes one element from each of four cached filter vectors (b0..b3) per beat, plus the matching element of the input activation vector.
- Multiplies each pair and accumulates four Q8.8 dot products over a vector.
- Emits all four saturated results together with a valid/ready handshake to the next layer stage.

Parameters:
- DATA_W, 16, element width; signed fixed point.
- FRAC_W, 8, fractional bits of every element and result.
- ACC_W, 40, accumulator width; must be at least 2*DATA_W + log2(NUM_ELEMENTS).
- NUM_ELEMENTS, 16, elements per vector; also the expected beat count per vector.

Ports:
- clock  in  1  rising-edge clock.
- clear_n  in  1  asynchronous active-low reset.
- en  in  1  beat qualifier; when low, no beat is consumed.
- b_element_ready  in  1  b0..b3_element, a_element and last_element are valid this cycle.
- b0_element, b1_element, b2_element, b3_element  in  DATA_W each  filter elements.
- a_element  in  DATA_W  input-vector element, aligned with the b elements.
- last_element  in  1  final beat of the current vector.
- result_ready  in  1  downstream accepts results.
- result_valid  out  1  result0..3 hold a completed dot product.
- result0, result1, result2, result3  out  DATA_W each  saturated Q8.8 dot products.
- length_error  out  1  sticky; the last vector had the wrong beat count.
- overrun  out  1  sticky; a result completed while the previous one was still unaccepted.

Behaviour:
- A beat is consumed when en && b_element_ready.
- All outputs reset to 0. State resets to ACCUM, with accumulators and beat_count at 0.

Pipeline:
- S1 registers four signed DATA_W x DATA_W products (2*DATA_W wide), together with beat valid and last flags.
- S2 adds each sign-extended product to its ACC_W accumulator.
  - If the S2 beat is last, the final sum goes to a finalize register.
  - The accumulator is reloaded with 0. A same-cycle next beat therefore starts a fresh sum with no bubble.
- S3 arithmetic-shifts each sum right by FRAC_W, truncating toward negative infinity.
- S3 then saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and registers the results into result0..3.
- S3 asserts result_valid.
- Latency from the last beat's consumption to result_valid is 3 cycles. Back-to-back vectors are supported at one beat per cycle.

Handshake:
- result_valid stays high and result0..3 hold until the cycle in which result_valid && result_ready.
- A new S3 completion while result_valid && !result_ready:
  - the new results overwrite the held ones;
  - result_valid stays high;
  - overrun is set.
- A completion in the same cycle as acceptance loads the new results with no overrun.

Beat counter:
- beat_count increments per consumed beat and clears on a last beat.
- On a last beat, length_error is set if beat_count != NUM_ELEMENTS-1.
- If beat_count reaches NUM_ELEMENTS-1 and a further non-last beat arrives:
  - length_error is set;
  - the count wraps to 0;
  - accumulation continues.

Other rules:
- length_error and overrun clear only on clear_n.
- Idle input cycles hold all pipeline contents; in-flight S1/S2/S3 data still drains.
- Asserting clear_n low mid-vector discards partial sums immediately.

Optional Feature:
- FILTER_DOT_PRODUCT_RELU_EN defined: S3 forces any negative saturated result to 0 before registering. This behaves as the ReLU activation.
- Undefined: signed results pass unchanged.

Decomposition:
- Shared package holds:
  - DATA_W and FRAC_W defaults;
  - Q8.8 saturation bounds as constants;
  - a typedef for a signed DATA_W element.
- One natural sub-module, mac_lane, is instantiated four times. It covers product register, accumulator, finalize, and shift/saturate for one filter.
- The top level owns beat_count, the handshake and the sticky flags.

Test Plan:
- Basic dot product:
  - Stimulus: 16 beats with a=0x0100 (1.0) and b0=0x0100, b1=0x0200, b2=0xFF00 (-1.0), b3=0x0080; last on beat 16.
  - Response: result0=0x1000, result1=0x2000, result2=0xF000, result3=0x0800; result_valid exactly 3 cycles after the last beat.
- Saturation:
  - Stimulus: 16 beats with a=b0=0x7FFF.
  - Response: result0=0x7FFF. With a=0x7FFF, b1=0x8000: result1=0x8000. With RELU_EN defined: result1=0x0000.
- Back-to-back vectors with result_ready tied high:
  - Stimulus: vector with all products 1.0 immediately followed by vector with all products 2.0.
  - Response: results 0x1000 then 0x2000 on consecutive valid windows; no carry-over between vectors.
- Backpressure:
  - Stimulus: hold result_ready low across two completions.
  - Response: second result visible, overrun=1, result_valid held until ready.
- Length error:
  - Stimulus: last_element on beat 10; separately, 17 beats before last.
  - Response: length_error=1 in both cases; results still produced.
- Reset:
  - Stimulus: drive clear_n low mid-vector at beat 7, then run a clean vector.
  - Response: all outputs 0 during reset; next result is correct with no residue from the aborted vector.
